// File: rtl/tdc_readout_fsm.sv
// tdc_readout_fsm
//   Captures thermometer snapshots from the TDC delay line and encodes each
//   one as a binary tap count. It averages 2^AVG_LOG2 samples per measurement
//   and presents one result byte on a valid/ready handshake.
// Ports
//   clk, rst_n   system clock, asynchronous active-low reset
//   ena          block enable; low aborts any measurement and drops the result
//   trig         single-cycle pulse that starts a measurement (IDLE only)
//   tap_in       delay-line snapshot; bit 0 is the tap nearest the start edge
//   tap_valid    tap_in is stable this cycle (accepted in WAIT only)
//   busy         high in every state except IDLE
//   rd_data      {ovf, bubble, avg} with avg zero-extended to 6 bits
//   rd_valid     rd_data is valid
//   rd_ready     consumer accepts rd_data
module tdc_readout_fsm #(
   parameter int unsigned TAPS     = 32,
   parameter int unsigned CNT_W    = 6,
   parameter int unsigned AVG_LOG2 = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            ena,
   input  logic            trig,
   input  logic [TAPS-1:0] tap_in,
   input  logic            tap_valid,
   output logic            busy,
   output logic [7:0]      rd_data,
   output logic            rd_valid,
   input  logic            rd_ready
);

   localparam int unsigned SUM_W = CNT_W + AVG_LOG2;

   // AVG sits between the last ENC and OUT so that the sum including the
   // final code is registered before the average is formed; this places the
   // rd_valid rise on the 2nd edge after the final tap_valid is sampled.
   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_ENC,
      S_AVG,
      S_OUT
   } state_t;

   state_t               r_state;
   state_t               w_next;
   logic [TAPS-1:0]      r_snap;
   logic [SUM_W-1:0]     r_sum;
   logic [AVG_LOG2:0]    r_cnt;
   logic                 r_ovf;
   logic                 r_bubble;
   logic [7:0]           r_rd_data;
   logic                 r_rd_valid;

   logic [CNT_W-1:0]     w_code;
   logic                 w_found;
   logic                 w_bub;
   logic                 w_all_ones;
   logic                 w_last;
   logic [SUM_W-1:0]     w_avg_full;
   logic [CNT_W-1:0]     w_avg;

   // Thermometer encoder: position of the lowest 0; any 1 above it is a bubble.
   always_comb begin
      w_code  = CNT_W'(TAPS);
      w_found = 1'b0;
      w_bub   = 1'b0;
      for (int unsigned i = 0; i < TAPS; i++) begin
         if (!w_found && !r_snap[i]) begin
            w_found = 1'b1;
            w_code  = CNT_W'(i);
         end else if (w_found && r_snap[i]) begin
            w_bub = 1'b1;
         end
      end
      w_all_ones = !w_found;
   end

   assign w_last     = (r_cnt == (AVG_LOG2+1)'((1 << AVG_LOG2) - 1));
   assign w_avg_full = r_sum >> AVG_LOG2;

   always_comb begin
      if (w_avg_full > SUM_W'((1 << CNT_W) - 1)) begin
         w_avg = '1;
      end else begin
         w_avg = CNT_W'(w_avg_full);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (trig) w_next = S_WAIT;
         S_WAIT:  if (tap_valid) w_next = S_ENC;
         S_ENC:   w_next = w_last ? S_AVG : S_WAIT;
         S_AVG:   w_next = S_OUT;
         S_OUT:   if (rd_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
      if (!ena) begin
         w_next = S_IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_snap     <= '0;
         r_sum      <= '0;
         r_cnt      <= '0;
         r_ovf      <= 1'b0;
         r_bubble   <= 1'b0;
         r_rd_data  <= '0;
         r_rd_valid <= 1'b0;
      end else begin
         r_rd_valid <= (w_next == S_OUT);
         if (!ena || r_state == S_IDLE) begin
            r_sum    <= '0;
            r_cnt    <= '0;
            r_ovf    <= 1'b0;
            r_bubble <= 1'b0;
         end else begin
            if (r_state == S_WAIT && tap_valid) begin
               r_snap <= tap_in;
            end
            if (r_state == S_ENC) begin
               r_sum    <= r_sum + SUM_W'(w_code);
               r_cnt    <= r_cnt + 1'b1;
               r_ovf    <= r_ovf | w_all_ones;
               r_bubble <= r_bubble | w_bub;
            end
            if (r_state == S_AVG) begin
               r_rd_data <= {r_ovf, r_bubble, 6'(w_avg)};
            end
         end
      end
   end

   assign busy     = (r_state != S_IDLE);
   assign rd_data  = r_rd_data;
   assign rd_valid = r_rd_valid;

endmodule

// File: tb/tb_tdc_readout_fsm.sv
// tb_tdc_readout_fsm
//   Directed bench for tdc_readout_fsm. Expected result bytes are pushed to a
//   scoreboard queue as the last sample of a measurement is driven and popped
//   when rd_valid rises.
module tb_tdc_readout_fsm;

   logic        clk;
   logic        rst_n;
   logic        ena;
   logic        trig;
   logic [31:0] tap_in;
   logic        tap_valid;
   logic        busy;
   logic [7:0]  rd_data;
   logic        rd_valid;
   logic        rd_ready;

   int unsigned checks = 0;
   int unsigned errors = 0;
   logic [7:0]  sb[$];

   tdc_readout_fsm #(
      .TAPS(32),
      .CNT_W(6),
      .AVG_LOG2(2)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .ena(ena),
      .trig(trig),
      .tap_in(tap_in),
      .tap_valid(tap_valid),
      .busy(busy),
      .rd_data(rd_data),
      .rd_valid(rd_valid),
      .rd_ready(rd_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge in IDLE; returns at the negedge with the FSM in WAIT.
   task automatic start();
      trig = 1'b1;
      @(negedge clk);
      trig = 1'b0;
   endtask

   // Pulses one snapshot in WAIT; returns after the ENC cycle has completed.
   task automatic send_tap(input logic [31:0] t);
      tap_in    = t;
      tap_valid = 1'b1;
      @(negedge clk);
      tap_valid = 1'b0;
      tap_in    = $urandom;
      chk("no_valid_in_enc", rd_valid, 1'b0);
      @(negedge clk);
   endtask

   // After the final send_tap: rd_valid must rise exactly one edge later.
   task automatic expect_out(input string tag);
      logic [7:0] exp;
      chk({tag, "_valid_lat1"}, rd_valid, 1'b0);
      @(negedge clk);
      chk({tag, "_valid_lat2"}, rd_valid, 1'b1);
      if (sb.size() == 0) begin
         chk({tag, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
         exp = sb.pop_front();
         chk({tag, "_data"}, rd_data, exp);
      end
   endtask

   task automatic accept(input string tag);
      rd_ready = 1'b1;
      @(negedge clk);
      rd_ready = 1'b0;
      chk({tag, "_valid_drop"}, rd_valid, 1'b0);
      chk({tag, "_idle"}, busy, 1'b0);
   endtask

   task automatic measure(input string tag, input logic [31:0] t0, input logic [31:0] t1,
                          input logic [31:0] t2, input logic [31:0] t3, input logic [7:0] exp);
      start();
      send_tap(t0);
      send_tap(t1);
      send_tap(t2);
      sb.push_back(exp);
      send_tap(t3);
      expect_out(tag);
   endtask

   initial begin
      logic [7:0] held;

      // Reset with random inputs
      rst_n     = 1'b0;
      rd_ready  = 1'b0;
      for (int i = 0; i < 4; i++) begin
         ena       = 1'($urandom);
         trig      = 1'($urandom);
         tap_valid = 1'($urandom);
         tap_in    = $urandom;
         rd_ready  = 1'($urandom);
         @(negedge clk);
         chk("rst_busy", busy, 1'b0);
         chk("rst_valid", rd_valid, 1'b0);
         chk("rst_data", rd_data, 8'h00);
      end
      ena = 1'b1; trig = 1'b0; tap_valid = 1'b0; rd_ready = 1'b0; tap_in = '0;
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_idle", busy, 1'b0);

      // Basic measurement and latency
      measure("ff", 32'h000000FF, 32'h000000FF, 32'h000000FF, 32'h000000FF, 8'h08);
      accept("ff");

      // Mixed codes 4,6,8,10
      measure("mixed", 32'h0000000F, 32'h0000003F, 32'h000000FF, 32'h000003FF, 8'h07);
      accept("mixed");

      // Bubble
      measure("bubble", 32'h0000F0FF, 32'h0000F0FF, 32'h0000F0FF, 32'h0000F0FF, 8'h48);
      accept("bubble");
      chk("hold_idle_bubble", rd_data, 8'h48);

      // Overflow with backpressure; trig and tap_valid in OUT are ignored
      measure("ovf", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 8'hA0);
      for (int i = 0; i < 10; i++) begin
         trig      = (i == 3);
         tap_valid = (i == 5);
         tap_in    = $urandom;
         @(negedge clk);
         chk("bp_valid", rd_valid, 1'b1);
         chk("bp_data", rd_data, 8'hA0);
      end
      trig = 1'b0; tap_valid = 1'b0;
      // trig in the acceptance cycle is ignored
      trig = 1'b1;
      accept("ovf");
      trig = 1'b0;
      @(negedge clk);
      chk("accept_trig_ignored", busy, 1'b0);
      chk("hold_idle_ovf", rd_data, 8'hA0);

      // tap_valid alone in IDLE is ignored
      tap_valid = 1'b1; tap_in = 32'hFFFFFFFF;
      @(negedge clk);
      tap_valid = 1'b0;
      chk("idle_tap_ignored", busy, 1'b0);

      // tap_valid together with trig: the snapshot is not taken
      trig = 1'b1; tap_valid = 1'b1; tap_in = 32'hFFFFFFFF;
      @(negedge clk);
      trig = 1'b0; tap_valid = 1'b0;
      chk("trig_tap_wait", busy, 1'b1);
      chk("hold_wait", rd_data, 8'hA0);
      send_tap(32'h0000000F);
      send_tap(32'h0000000F);
      send_tap(32'h0000000F);
      sb.push_back(8'h04);
      send_tap(32'h0000000F);
      expect_out("trig_tap");
      accept("trig_tap");

      // Abort after the 2nd sample
      start();
      send_tap(32'h000000FF);
      send_tap(32'h000000FF);
      ena = 1'b0;
      @(negedge clk);
      chk("abort_idle", busy, 1'b0);
      chk("abort_valid", rd_valid, 1'b0);
      trig = 1'b1;
      @(negedge clk);
      trig = 1'b0;
      chk("abort_trig_blocked", busy, 1'b0);
      ena = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("abort_no_valid", rd_valid, 1'b0);
         chk("abort_hold_data", rd_data, 8'h04);
      end
      // Sum and flags from the aborted run must not leak into this one
      measure("after_abort", 32'h0000003F, 32'h0000003F, 32'h0000003F, 32'h0000003F, 8'h06);
      accept("after_abort");

      // Asynchronous reset mid-measurement
      start();
      send_tap(32'h0000000F);
      held = rd_data;
      chk("pre_areset_busy", busy, 1'b1);
      chk("pre_areset_data", held, 8'h06);
      #2 rst_n = 1'b0;
      #1;
      chk("areset_busy", busy, 1'b0);
      chk("areset_data", rd_data, 8'h00);
      chk("areset_valid", rd_valid, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("areset_stays_idle", busy, 1'b0);
      chk("sb_drained", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
